fetch1: RTL and testbench
=========================

Name: fetch1

Overview:
First instruction-fetch stage. It holds the architectural fetch PC, selects the next PC and issues the I-cache request. The next PC comes from backend redirects, the fetch2 branch-misprediction redirect, the BTB prediction or sequential PC+4. Each accepted request produces one fetch1_fetch2_pass_t / excp_pass_t beat to fetch2. Fetch1 also raises ADEF for misaligned PCs and parks until it is redirected.

Parameters:
RESET_PC, 32'h1c00_0000, PC loaded on reset (LoongArch boot address).
ADEF_CODE, 15'h0008, esubcode_ecode value for ADEF ({9'd0, 6'h08}).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  backend pipeline flush; always paired with be_wr_pc_req.valid
be_wr_pc_req  in  wr_pc_req_t  backend redirect (exception/ertn/branch resolve)
bp_wr_pc_req  in  wr_pc_req_t  fetch2 misprediction redirect (valid coincides with bp_error_flush)
next_rdy_in  in  1  fetch2 rdy_in
btb_pc  out  32  BTB lookup address (= pc_r, combinational)
btb_hit  in  1  BTB hit for btb_pc, same cycle
btb_target  in  32  predicted target, same cycle
icache_req  out  1  fetch request valid
icache_addr  out  32  fetch address (= pc_r)
icache_ready  in  1  cache accepts request this cycle
pass_out  out  fetch1_fetch2_pass_t  {valid, pc, btb_pre, is_pred}
excp_pass_out  out  excp_pass_t  {valid, esubcode_ecode, badv}

Behaviour:
- Reset (async, rst_n=0): pc_r=RESET_PC; state=RUN; pass_out.valid=0; excp_pass_out.valid=0; icache_req=0.
- redirect = be_wr_pc_req.valid | bp_wr_pc_req.valid.
- Priority when both redirects are valid: be_wr_pc_req wins.
- misalign = |pc_r[1:0].
- State RUN:
  - icache_req = next_rdy_in & ~redirect & ~flush & ~misalign.
  - fire = icache_req & icache_ready.
- State ADEF_HOLD: icache_req=0; fire=0.
- pass_out is combinational from pc_r:
  - valid = fire | adef_emit.
  - pc = pc_r.
  - is_pred = btb_hit.
  - btb_pre = btb_hit ? btb_target : pc_r+4.
- adef_emit = (state==RUN) & misalign & next_rdy_in & ~redirect & ~flush.
  - excp_pass_out.valid = adef_emit; esubcode_ecode = ADEF_CODE; badv = pc_r.
  - When adef_emit=0: excp_pass_out.valid=0 and other fields are don't-care.
- Next pc_r, in priority order:
  1. be_wr_pc_req.pc
  2. bp_wr_pc_req.pc
  3. fire ? pass_out.btb_pre : pc_r
  - 32-bit add; wraps 32'hFFFF_FFFC -> 0.
- State transitions:
  - RUN -> ADEF_HOLD on adef_emit.
  - ADEF_HOLD -> RUN on any redirect.
  - Any state -> RUN on redirect; the redirect has priority over adef_emit.
- Latency: the redirect target is issued as icache_addr the cycle after the redirect, at the earliest.
- Stall cases: with next_rdy_in=0 or icache_ready=0, pc_r holds and no beat is emitted.
  - The BTB is re-looked-up every cycle, so a changed BTB entry is used at fire time.
- Flush and redirect in the same cycle: no request and no beat that cycle; pc_r loads the target.
- Redirect to a misaligned target: one fetch-free ADEF beat is emitted the following cycle, then ADEF_HOLD.
- Reset mid-stall or mid-ADEF_HOLD: returns to RUN at RESET_PC with no residual beat.

Decomposition:
- Shared package cpu_defs: wr_pc_req_t, fetch1_fetch2_pass_t, excp_pass_t, ECODE_ADEF / ESUBCODE constants, RESET_PC default.
- One natural sub-module: npc_sel (combinational next-PC priority mux).
- The state register and PC register stay in fetch1.

Test Plan:
- Reset release, next_rdy_in=1, icache_ready=1, btb_hit=0 -> icache_addr sequence 1c000000, 1c000004, 1c000008; pass_out.is_pred=0; btb_pre=pc+4.
- At pc 1c000010: btb_hit=1, btb_target=1c000100 -> beat {pc=1c000010, is_pred=1, btb_pre=1c000100}; next icache_addr=1c000100.
- icache_ready=0 for 3 cycles at pc 1c000020 -> no pass_out.valid; pc holds. On ready -> single beat at 1c000020, then 1c000024.
- Same cycle: be_wr_pc_req={1,1c008000}, bp_wr_pc_req={1,1c000200}, flush=1 -> no beat that cycle; next icache_addr=1c008000.
- Redirect to 1c000102 -> next cycle excp_pass_out {valid=1, esubcode_ecode=0008, badv=1c000102}, no icache_req. Then idle until be_wr_pc_req={1,1c00f000}, after which fetching resumes at 1c00f000.
- rst_n pulsed low while in ADEF_HOLD -> outputs invalid immediately; after release fetch restarts at 1c000000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared front-end definitions: redirect requests, fetch1->fetch2 beats,
// exception beats and the boot/ADEF constants.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF  = 32'h1c00_0000;
    localparam logic [5:0]  ECODE_ADEF    = 6'h08;
    localparam logic [8:0]  ESUBCODE_ADEF = 9'd0;
    localparam logic [14:0] ADEF_CODE_DEF = {ESUBCODE_ADEF, ECODE_ADEF};

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } wr_pc_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] btb_pre;
        logic        is_pred;
    } fetch1_fetch2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [14:0] esubcode_ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef enum logic {
        RUN       = 1'b0,
        ADEF_HOLD = 1'b1
    } f1_state_t;

endpackage

// File: rtl/fetch1_npc_sel.sv
// Next-PC priority mux: backend redirect, then fetch2 redirect,
// then the predicted/sequential PC on a fired request, else hold.
module npc_sel
    import cpu_defs::*;
(
    input  wr_pc_req_t  be_req,
    input  wr_pc_req_t  bp_req,
    input  logic        fire,
    input  logic [31:0] btb_pre,
    input  logic [31:0] pc,
    output logic [31:0] npc
);

    // Backend redirects outrank fetch2 redirects, which outrank fetch progress
    always_comb begin
        npc = pc;
        if (be_req.valid) begin
            npc = be_req.pc;
        end else if (bp_req.valid) begin
            npc = bp_req.pc;
        end else if (fire) begin
            npc = btb_pre;
        end
    end

endmodule

// File: rtl/fetch1.sv
// First fetch stage: owns the fetch PC, issues I-cache requests,
// hands beats to fetch2 and parks after an ADEF until redirected.
module fetch1
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [14:0] ADEF_CODE = ADEF_CODE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  wr_pc_req_t          be_wr_pc_req,
    input  wr_pc_req_t          bp_wr_pc_req,
    input  logic                next_rdy_in,
    output logic [31:0]         btb_pc,
    input  logic                btb_hit,
    input  logic [31:0]         btb_target,
    output logic                icache_req,
    output logic [31:0]         icache_addr,
    input  logic                icache_ready,
    output fetch1_fetch2_pass_t pass_out,
    output excp_pass_t          excp_pass_out
);

    logic [31:0] pc_r;
    logic [31:0] npc;
    logic [31:0] btb_pre;
    f1_state_t   state;
    logic        redirect;
    logic        misalign;
    logic        go;
    logic        fire;
    logic        adef_emit;

    assign redirect = be_wr_pc_req.valid | bp_wr_pc_req.valid;
    assign misalign = |pc_r[1:0];

    // rst_n gates the handshake so nothing leaks out while reset is held
    assign go = rst_n & (state == RUN) & next_rdy_in & ~redirect & ~flush;

    assign icache_req = go & ~misalign;
    assign fire       = icache_req & icache_ready;
    assign adef_emit  = go & misalign;

    assign btb_pc      = pc_r;
    assign icache_addr = pc_r;
    assign btb_pre     = btb_hit ? btb_target : pc_r + 32'd4;

    // Beat to fetch2 is built every cycle from the current PC and BTB result
    always_comb begin
        pass_out.valid   = fire | adef_emit;
        pass_out.pc      = pc_r;
        pass_out.btb_pre = btb_pre;
        pass_out.is_pred = btb_hit;
    end

    // ADEF beat carries the faulting PC as bad virtual address
    always_comb begin
        excp_pass_out.valid          = adef_emit;
        excp_pass_out.esubcode_ecode = ADEF_CODE;
        excp_pass_out.badv           = pc_r;
    end

    npc_sel u_npc_sel (
        .be_req  (be_wr_pc_req),
        .bp_req  (bp_wr_pc_req),
        .fire    (fire),
        .btb_pre (btb_pre),
        .pc      (pc_r),
        .npc     (npc)
    );

    // PC register and RUN/ADEF_HOLD state; redirects always win over ADEF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r  <= RESET_PC;
            state <= RUN;
        end else begin
            pc_r <= npc;
            if (redirect) begin
                state <= RUN;
            end else if (adef_emit) begin
                state <= ADEF_HOLD;
            end
        end
    end

endmodule

// File: tb/tb_fetch1.sv
// Directed table-driven bench for fetch1 plus hand-written reset and
// ADEF sequences.
module tb_fetch1;
    import cpu_defs::*;

    logic                clk;
    logic                rst_n;
    logic                flush;
    wr_pc_req_t          be_wr_pc_req;
    wr_pc_req_t          bp_wr_pc_req;
    logic                next_rdy_in;
    logic [31:0]         btb_pc;
    logic                btb_hit;
    logic [31:0]         btb_target;
    logic                icache_req;
    logic [31:0]         icache_addr;
    logic                icache_ready;
    fetch1_fetch2_pass_t pass_out;
    excp_pass_t          excp_pass_out;

    int checks;
    int failures;

    fetch1 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .be_wr_pc_req  (be_wr_pc_req),
        .bp_wr_pc_req  (bp_wr_pc_req),
        .next_rdy_in   (next_rdy_in),
        .btb_pc        (btb_pc),
        .btb_hit       (btb_hit),
        .btb_target    (btb_target),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ready  (icache_ready),
        .pass_out      (pass_out),
        .excp_pass_out (excp_pass_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        crdy;
        logic        hit;
        logic [31:0] tgt;
        logic        be_v;
        logic [31:0] be_pc;
        logic        bp_v;
        logic [31:0] bp_pc;
        logic        fl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_pv;
        logic [31:0] e_pre;
        logic        e_ip;
        logic        e_ev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rdy, input logic crdy, input logic hit,
        input logic [31:0] tgt,
        input logic be_v, input logic [31:0] be_pc,
        input logic bp_v, input logic [31:0] bp_pc,
        input logic fl,
        input logic e_req, input logic [31:0] e_addr,
        input logic e_pv, input logic [31:0] e_pre,
        input logic e_ip, input logic e_ev);
        vec_t v;
        v.rdy = rdy; v.crdy = crdy; v.hit = hit; v.tgt = tgt;
        v.be_v = be_v; v.be_pc = be_pc;
        v.bp_v = bp_v; v.bp_pc = bp_pc; v.fl = fl;
        v.e_req = e_req; v.e_addr = e_addr; v.e_pv = e_pv;
        v.e_pre = e_pre; v.e_ip = e_ip; v.e_ev = e_ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        next_rdy_in        = v.rdy;
        icache_ready       = v.crdy;
        btb_hit            = v.hit;
        btb_target         = v.tgt;
        be_wr_pc_req.valid = v.be_v;
        be_wr_pc_req.pc    = v.be_pc;
        bp_wr_pc_req.valid = v.bp_v;
        bp_wr_pc_req.pc    = v.bp_pc;
        flush              = v.fl;
    endtask

    task automatic compare(input int idx, input vec_t v);
        string s;
        s = $sformatf("row%0d", idx);
        chk({s, ".icache_req"}, {31'd0, icache_req}, {31'd0, v.e_req});
        chk({s, ".icache_addr"}, icache_addr, v.e_addr);
        chk({s, ".btb_pc"}, btb_pc, v.e_addr);
        chk({s, ".pass_valid"}, {31'd0, pass_out.valid}, {31'd0, v.e_pv});
        chk({s, ".excp_valid"}, {31'd0, excp_pass_out.valid},
            {31'd0, v.e_ev});
        if (v.e_pv) begin
            chk({s, ".pass_pc"}, pass_out.pc, v.e_addr);
            chk({s, ".btb_pre"}, pass_out.btb_pre, v.e_pre);
            chk({s, ".is_pred"}, {31'd0, pass_out.is_pred},
                {31'd0, v.e_ip});
        end
        if (v.e_ev) begin
            chk({s, ".ecode"}, {17'd0, excp_pass_out.esubcode_ecode},
                32'h0000_0008);
            chk({s, ".badv"}, excp_pass_out.badv, v.e_addr);
        end
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        next_rdy_in  = 1'b1;
        icache_ready = 1'b1;

        // reset state with a ready consumer: nothing may be requested
        #12;
        chk("rst.icache_req", {31'd0, icache_req}, 32'd0);
        chk("rst.pass_valid", {31'd0, pass_out.valid}, 32'd0);
        chk("rst.excp_valid", {31'd0, excp_pass_out.valid}, 32'd0);
        chk("rst.icache_addr", icache_addr, 32'h1c00_0000);

        @(negedge clk);
        idle();
        rst_n = 1'b1;

        //          rdy crdy hit tgt     be_v be_pc      bp_v bp_pc  fl
        //          req addr          pv pre          ip ev
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000000, 1,32'h1c000004, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000004, 1,32'h1c000008, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000008, 1,32'h1c00000c, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c00000c, 1,32'h1c000010, 0,0));
        vecs.push_back(mk(1,1,1,32'h1c000100, 0,0, 0,0, 0,
                          1,32'h1c000010, 1,32'h1c000100, 1,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000100, 1,32'h1c000104, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 1,32'h1c000020, 0,
                          0,32'h1c000104, 0,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,
                          1,32'h1c000020, 0,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,
                          1,32'h1c000020, 0,0, 0,0));
        vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,
                          1,32'h1c000020, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000020, 1,32'h1c000024, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c000024, 1,32'h1c000028, 0,0));
        vecs.push_back(mk(1,1,0,0, 1,32'h1c008000, 1,32'h1c000200, 1,
                          0,32'h1c000028, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c008000, 1,32'h1c008004, 0,0));
        vecs.push_back(mk(1,1,0,0, 1,32'h1c000102, 0,0, 0,
                          0,32'h1c008004, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          0,32'h1c000102, 1,32'h1c000106, 0,1));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          0,32'h1c000102, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          0,32'h1c000102, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 1,32'h1c00f000, 0,0, 0,
                          0,32'h1c000102, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c00f000, 1,32'h1c00f004, 0,0));
        vecs.push_back(mk(0,1,0,0, 0,0, 0,0, 0,
                          0,32'h1c00f004, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h1c00f004, 1,32'h1c00f008, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 1,32'hfffffffc, 0,
                          0,32'h1c00f008, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'hfffffffc, 1,32'h00000000, 0,0));
        vecs.push_back(mk(1,1,0,0, 0,0, 0,0, 0,
                          1,32'h00000000, 1,32'h00000004, 0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            compare(i, vecs[i]);
        end

        // ADEF_HOLD then asynchronous reset mid-cycle
        @(negedge clk);
        drive(mk(1,1,0,0, 1,32'h1c000202, 0,0, 0,
                 0,0, 0,0, 0,0));
        @(negedge clk);
        idle();
        next_rdy_in  = 1'b1;
        icache_ready = 1'b1;
        #1;
        chk("adef2.excp_valid", {31'd0, excp_pass_out.valid}, 32'd1);
        chk("adef2.badv", excp_pass_out.badv, 32'h1c00_0202);
        @(negedge clk);
        #1;
        chk("hold2.excp_valid", {31'd0, excp_pass_out.valid}, 32'd0);
        chk("hold2.icache_req", {31'd0, icache_req}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.icache_req", {31'd0, icache_req}, 32'd0);
        chk("arst.pass_valid", {31'd0, pass_out.valid}, 32'd0);
        chk("arst.excp_valid", {31'd0, excp_pass_out.valid}, 32'd0);
        chk("arst.icache_addr", icache_addr, 32'h1c00_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel.icache_req", {31'd0, icache_req}, 32'd1);
        chk("rel.pass_valid", {31'd0, pass_out.valid}, 32'd1);
        chk("rel.icache_addr", icache_addr, 32'h1c00_0000);
        @(negedge clk);
        #1;
        chk("rel2.icache_addr", icache_addr, 32'h1c00_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
